cpu_sequencer: RTL

Program sequencer that drives the 9-bit CPU's `DIN`/`run` inputs from a synchronous-read program memory. It fetches each instruction word, pulses `run`, supplies the immediate word for `mvi`, and waits for `Done` before advancing. It sits between the program ROM and the CPU top, replacing manual switch and button stimulus. Status outputs expose the program counter, the retired-instruction count and the halt/error state.

---
 rtl/cpu_seq_pkg.sv | 29 ++
 rtl/seq_watchdog.sv | 28 ++
 rtl/cpu_sequencer.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/cpu_seq_pkg.sv
// Shared types and constants for the CPU program sequencer.
package cpu_seq_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_ISSUE,
    S_IMM,
    S_WAIT,
    S_HALTED,
    S_ERROR
  } state_t;

  localparam logic [2:0] OP_MVI    = 3'b001;
  localparam logic [8:0] HALT_WORD = 9'h1FF;

  // Instruction word fields: [8:6] opcode, [5:3] X, [2:0] Y
  localparam int OPC_MSB = 8;
  localparam int OPC_LSB = 6;
  localparam int X_MSB   = 5;
  localparam int X_LSB   = 3;
  localparam int Y_MSB   = 2;
  localparam int Y_LSB   = 0;

  function automatic logic [2:0] opcode_of(input logic [8:0] word);
    return word[OPC_MSB:OPC_LSB];
  endfunction

endpackage

// File: rtl/seq_watchdog.sv
// Cycle watchdog for the sequencer: expires on the TIMEOUT-th consecutive enabled cycle.
module seq_watchdog #(
  parameter int TIMEOUT = 31
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expired
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if (i_clear) begin
      r_cnt <= '0;
    end else if (i_enable && (r_cnt != CNT_W'(TIMEOUT))) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_expired = i_enable && (r_cnt == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/cpu_sequencer.sv
// Program sequencer feeding DIN/run of the 9-bit CPU from a synchronous-read ROM.
// Optional Done watchdog enabled by defining CPU_SEQ_TIMEOUT_EN.
module cpu_sequencer
  import cpu_seq_pkg::*;
#(
  parameter int ADDR_W  = 6,
  parameter int TIMEOUT = 31
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_start,
  input  logic              i_halt_req,
  output logic [ADDR_W-1:0] o_mem_addr,
  input  logic [8:0]        i_mem_rdata,
  output logic [8:0]        o_din,
  output logic              o_run,
  input  logic              i_done,
  output logic              o_busy,
  output logic              o_halted,
  output logic              o_error,
  output logic [ADDR_W-1:0] o_pc,
  output logic [15:0]       o_retired
);

  state_t              r_state;
  state_t              w_state_next;
  logic [ADDR_W-1:0]   r_pc;
  logic [ADDR_W-1:0]   w_pc_next;
  logic [15:0]         r_retired;
  logic [15:0]         w_retired_next;
  logic                r_is_mvi;
  logic                w_is_mvi_next;
  logic                r_busy;
  logic                r_halted;
  logic                w_retire;
  logic                w_expired;
  logic                w_in_exec;
  logic [ADDR_W:0]     w_step_sum;

  assign w_in_exec  = (r_state == S_IMM) || (r_state == S_WAIT);
  // Extra MSB catches the carry that marks running off the end of memory
  assign w_step_sum = {1'b0, r_pc} + (r_is_mvi ? (ADDR_W+1)'(2) : (ADDR_W+1)'(1));

`ifdef CPU_SEQ_TIMEOUT_EN
  logic r_error;

  seq_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .i_clear   (!w_in_exec),
    .i_enable  (w_in_exec),
    .o_expired (w_expired)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_error <= 1'b0;
    end else begin
      r_error <= (w_state_next == S_ERROR);
    end
  end

  assign o_error = r_error;
`else
  assign w_expired = 1'b0;
  assign o_error   = 1'b0;
`endif

  always_comb begin
    w_state_next   = r_state;
    w_pc_next      = r_pc;
    w_retired_next = r_retired;
    w_is_mvi_next  = r_is_mvi;
    w_retire       = 1'b0;
    o_mem_addr     = r_pc;
    o_din          = 9'd0;
    o_run          = 1'b0;

    case (r_state)
      S_IDLE, S_HALTED, S_ERROR: begin
        if (i_start) begin
          w_pc_next      = '0;
          w_retired_next = '0;
          w_state_next   = S_FETCH;
        end
      end
      S_FETCH: begin
        w_state_next = S_ISSUE;
      end
      S_ISSUE: begin
        if (i_mem_rdata == HALT_WORD) begin
          w_state_next = S_HALTED;
        end else begin
          o_din = i_mem_rdata;
          o_run = 1'b1;
          if (opcode_of(i_mem_rdata) == OP_MVI) begin
            o_mem_addr    = r_pc + 1'b1;
            w_is_mvi_next = 1'b1;
            w_state_next  = S_IMM;
          end else begin
            w_is_mvi_next = 1'b0;
            w_state_next  = S_WAIT;
          end
        end
      end
      S_IMM: begin
        o_din = i_mem_rdata;
        if (i_done) begin
          w_retire = 1'b1;
        end else if (w_expired) begin
          w_state_next = S_ERROR;
        end else begin
          w_state_next = S_WAIT;
        end
      end
      S_WAIT: begin
        if (i_done) begin
          w_retire = 1'b1;
        end else if (w_expired) begin
          w_state_next = S_ERROR;
        end
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase

    if (w_retire) begin
      w_retired_next = (r_retired == 16'hFFFF) ? r_retired : r_retired + 16'd1;
      w_pc_next      = w_step_sum[ADDR_W-1:0];
      w_state_next   = (i_halt_req || w_step_sum[ADDR_W]) ? S_HALTED : S_FETCH;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state   <= S_IDLE;
      r_pc      <= '0;
      r_retired <= '0;
      r_is_mvi  <= 1'b0;
      r_busy    <= 1'b0;
      r_halted  <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_pc      <= w_pc_next;
      r_retired <= w_retired_next;
      r_is_mvi  <= w_is_mvi_next;
      r_busy    <= (w_state_next != S_IDLE) && (w_state_next != S_HALTED) &&
                   (w_state_next != S_ERROR);
      r_halted  <= (w_state_next == S_HALTED);
    end
  end

  assign o_busy    = r_busy;
  assign o_halted  = r_halted;
  assign o_pc      = r_pc;
  assign o_retired = r_retired;

endmodule
